// File: rtl/timer_scheduler_4ch_pkg.sv
// Shared constants, state encoding and helpers for the four-channel timer scheduler.
package timer_scheduler_4ch_pkg;

  localparam int SCHED_NUM_REQ     = 4;
  localparam int SCHED_TIMER_WIDTH = 16;

  // One-hot so busy can be decoded from a single state bit without glitches.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CLEAR = 4'b0010,
    S_RUN   = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/timer_scheduler_4ch_if.sv
// Requester-side bundle of the timer scheduler: requests, final values, grant/done/busy.
interface timer_scheduler_4ch_if;
  import timer_scheduler_4ch_pkg::*;

  logic [SCHED_NUM_REQ-1:0]                   req;
  logic [SCHED_NUM_REQ*SCHED_TIMER_WIDTH-1:0] req_final_value;
  logic [SCHED_NUM_REQ-1:0]                   grant;
  logic [SCHED_NUM_REQ-1:0]                   done;
  logic                                       busy;

  modport master (
    output req,
    output req_final_value,
    input  grant,
    input  done,
    input  busy
  );

  modport slave (
    input  req,
    input  req_final_value,
    output grant,
    output done,
    output busy
  );

endinterface

// File: rtl/timer_scheduler_4ch_timer.sv
// Up-counting delay timer: synchronous active-low clear, counts while active, done on equality.
module timer_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear_n,
  input  logic             active,
  input  logic [WIDTH-1:0] final_value,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (!clear_n) begin
      count_reg <= '0;
    end else if (active) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Equality exit means the count never reaches its wrap point in use.
  assign done = active && (count_reg == final_value);

endmodule

// File: rtl/timer_scheduler_4ch.sv
// Round-robin scheduler sharing one delay timer among four requesters.
module timer_scheduler_4ch
  import timer_scheduler_4ch_pkg::*;
#(
  parameter int NUM_REQ     = SCHED_NUM_REQ,
  parameter int TIMER_WIDTH = SCHED_TIMER_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  timer_scheduler_4ch_if.slave  bus
);

  state_t                 state_reg, state_next;
  logic [1:0]             rr_ptr_reg;
  logic [1:0]             owner_reg;
  logic [NUM_REQ-1:0]     grant_reg;
  logic [NUM_REQ-1:0]     done_reg;
  logic [TIMER_WIDTH-1:0] final_reg;

  logic [TIMER_WIDTH-1:0] final_slice [NUM_REQ];
  logic [1:0]             winner;
  logic                   cancel;
  logic                   timer_clear_n;
  logic                   timer_active;
  logic                   timer_done;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign final_slice[gi] = bus.req_final_value[gi*TIMER_WIDTH +: TIMER_WIDTH];
  end

  // First set bit at or after ptr, wrapping; the smallest offset is assigned last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  assign winner = rr_pick(bus.req, rr_ptr_reg);

  always_comb begin
    state_next    = state_reg;
    cancel        = 1'b0;
    timer_clear_n = 1'b1;
    timer_active  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        timer_clear_n = 1'b0;
        if (|bus.req) begin
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        timer_clear_n = 1'b0;
        if (!bus.req[owner_reg]) begin
          cancel     = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        timer_active = 1'b1;
        if (!bus.req[owner_reg]) begin
          cancel        = 1'b1;
          timer_clear_n = 1'b0;
          state_next    = S_IDLE;
        end else if (timer_done) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= S_IDLE;
      rr_ptr_reg <= 2'd0;
      owner_reg  <= 2'd0;
      grant_reg  <= '0;
      done_reg   <= '0;
      final_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && state_next == S_CLEAR) begin
        owner_reg <= winner;
        grant_reg <= onehot4(winner);
        final_reg <= final_slice[winner];
      end
      if (cancel || state_reg == S_DONE) begin
        grant_reg  <= '0;
        rr_ptr_reg <= owner_reg + 2'd1;
      end
      // Pulse lands exactly in the DONE cycle because it is registered on entry.
      done_reg <= (state_next == S_DONE) ? grant_reg : '0;
    end
  end

  timer_16bit #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clock       (clock),
    .resetn      (resetn),
    .clear_n     (timer_clear_n),
    .active      (timer_active),
    .final_value (final_reg),
    .done        (timer_done)
  );

  assign bus.grant = grant_reg;
  assign bus.done  = done_reg;
  assign bus.busy  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_timer_scheduler_4ch.sv
// Directed bench for timer_scheduler_4ch: latency, arbitration order, cancel, reset, full-range delay.
module tb_timer_scheduler_4ch;
  import timer_scheduler_4ch_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always #5 clock = ~clock;

  timer_scheduler_4ch_if bus_if ();

  timer_scheduler_4ch dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_final(input int ch, input logic [15:0] v);
    bus_if.req_final_value[ch*16 +: 16] = v;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    bus_if.req = '0;
    @(negedge clock);
    resetn = 1'b1;
    tick();
  endtask

  // Cycle 0 is the current IDLE cycle in which req[ch] is first sampled.
  task automatic run_one(input int ch, input logic [15:0] fv, input string tag);
    int         done_cyc;
    logic [3:0] done_val;
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << ch;
    set_final(ch, fv);
    bus_if.req[ch] = 1'b1;
    tick();
    chk({tag, " grant@1"}, 32'(bus_if.grant), 32'(exp_oh));
    chk({tag, " busy@1"}, 32'(bus_if.busy), 32'd1);
    set_final(ch, ~fv);
    done_cyc = -1;
    done_val = '0;
    for (int c = 2; c <= int'(fv) + 10; c++) begin
      tick();
      if (bus_if.done != 4'b0000) begin
        done_cyc = c;
        done_val = bus_if.done;
        break;
      end
    end
    chk({tag, " done cycle"}, 32'(done_cyc), 32'(int'(fv) + 3));
    chk({tag, " done value"}, 32'(done_val), 32'(exp_oh));
    bus_if.req[ch] = 1'b0;
    tick();
    chk({tag, " done cleared"}, 32'(bus_if.done), 32'd0);
    chk({tag, " busy idle"}, 32'(bus_if.busy), 32'd0);
    chk({tag, " grant idle"}, 32'(bus_if.grant), 32'd0);
  endtask

  initial begin
    int         k;
    int         gcyc;
    int         done_cyc;
    logic [3:0] prev_grant;
    logic       saw_done1;

    bus_if.req             = '0;
    bus_if.req_final_value = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset grant", 32'(bus_if.grant), 32'd0);
    chk("reset done", 32'(bus_if.done), 32'd0);
    chk("reset busy", 32'(bus_if.busy), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    tick();

    run_one(2, 16'd5, "single r2 f5");
    run_one(0, 16'd0, "zero r0 f0");

    // All four requesting with rr_ptr freshly reset to 0.
    do_reset();
    for (int i = 0; i < 4; i++) set_final(i, 16'd3);
    bus_if.req = 4'b1111;
    k          = 0;
    gcyc       = 0;
    prev_grant = '0;
    for (int c = 1; c <= 60 && k < 4; c++) begin
      tick();
      if (bus_if.grant != 4'b0000 && prev_grant == 4'b0000) gcyc = c;
      prev_grant = bus_if.grant;
      if (bus_if.done != 4'b0000) begin
        chk($sformatf("rr done order %0d", k), 32'(bus_if.done), 32'(4'b0001 << k));
        chk($sformatf("rr done cycle %0d", k), 32'(c), 32'(6 + 7 * k));
        chk($sformatf("rr grant-to-done %0d", k), 32'(c - gcyc), 32'd5);
        bus_if.req = bus_if.req & ~bus_if.done;
        k++;
      end
    end
    chk("rr all served", 32'(k), 32'd4);
    tick();
    chk("rr busy idle", 32'(bus_if.busy), 32'd0);
    bus_if.req = 4'b1001;
    tick();
    chk("rr ptr back to 0", 32'(bus_if.grant), 32'h1);
    bus_if.req = '0;
    tick();
    chk("cancel in clear busy", 32'(bus_if.busy), 32'd0);

    // Cancel mid-RUN with another requester waiting.
    set_final(1, 16'd100);
    bus_if.req = 4'b0010;
    saw_done1  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus_if.done[1]) saw_done1 = 1'b1;
      if (c == 5) begin
        set_final(3, 16'd2);
        bus_if.req[3] = 1'b1;
      end
      if (c == 20) bus_if.req[1] = 1'b0;
    end
    tick();
    chk("cancel busy@21", 32'(bus_if.busy), 32'd0);
    chk("cancel grant@21", 32'(bus_if.grant), 32'd0);
    tick();
    chk("cancel next grant@22", 32'(bus_if.grant), 32'h8);
    done_cyc = -1;
    for (int c = 23; c <= 40; c++) begin
      tick();
      if (bus_if.done[1]) saw_done1 = 1'b1;
      if (bus_if.done != 4'b0000) begin
        done_cyc = c;
        chk("cancel r3 done value", 32'(bus_if.done), 32'h8);
        break;
      end
    end
    chk("cancel r3 done cycle", 32'(done_cyc), 32'd26);
    chk("cancel no done r1", 32'(saw_done1), 32'd0);
    bus_if.req = '0;
    tick();

    // Asynchronous reset in the middle of a long delay.
    set_final(0, 16'd1000);
    bus_if.req = 4'b0001;
    repeat (10) tick();
    chk("pre-reset busy", 32'(bus_if.busy), 32'd1);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("async reset grant", 32'(bus_if.grant), 32'd0);
    chk("async reset done", 32'(bus_if.done), 32'd0);
    chk("async reset busy", 32'(bus_if.busy), 32'd0);
    bus_if.req = '0;
    @(negedge clock);
    resetn = 1'b1;
    tick();
    run_one(0, 16'd2, "post-reset r0 f2");

    run_one(3, 16'hFFFF, "full-range r3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
